execute_stage_pipe: RTL and testbench
=====================================

Name: execute_stage_pipe

Overview:
Parametrised, registered execute stage for the RISC pipeline. It sits between the decode/ID-EX buffer and the EX-MEM buffer.
- Adds a valid/ready handshake, an internal flags register (Z/C/N) and an internal stack pointer.
- Adds a multi-cycle multiply that stalls upstream.
- Adds a pipeline flush.
- Control bits for later stages pass through unchanged, aligned with the result.

Parameters:
DATA_W, 16, operand/result width
SP_W, 32, stack pointer width
SP_INIT, 32'h0000_07FE, stack pointer value after reset
CTRL_W, 12, width of pass-through control bundle (MEM, WB, LDD, SP_OP, Rsrc/Rdst addresses)
MUL_CYCLES, 4, multiply latency in cycles (>=2)

Ports:
CLK  in  1  clock, rising edge
Reset  in  1  asynchronous, active-low reset
flush  in  1  synchronous squash of in-flight and output instruction
in_valid  in  1  upstream instruction valid
in_ready  out  1  stage can accept this cycle
src_val  in  DATA_W  Rsrc value
dst_val  in  DATA_W  Rdst value
imm  in  DATA_W  immediate
alu_op  in  4  operation code (package enum)
zero_src  in  1  first operand forced to 0
use_imm  in  1  second operand = imm instead of dst_val
sp_op  in  2  00 none, 01 push, 10 pop, 11 reserved (no-op)
ctrl_in  in  CTRL_W  pass-through control
out_valid  out  1  output registers hold an instruction
out_ready  in  1  downstream accepts
result  out  DATA_W  ALU result
src_out  out  DATA_W  registered src_val (store data)
sp_out  out  SP_W  memory address for stack op
flags  out  3  {N,C,Z} register
ctrl_out  out  CTRL_W  registered ctrl_in

Behaviour:
- Reset (async, Reset=0) puts the block in this state:
  - Outputs: out_valid=0, result=0, src_out=0, ctrl_out=0, flags=0.
  - SP=SP_INIT, sp_out=SP_INIT.
  - FSM=IDLE, mul counter=0.
  - Reset mid-multiply discards the multiply with no residue.
- in_ready = (state==IDLE) && (!out_valid || out_ready) && !flush.
- Accept = in_valid && in_ready.
- Operands:
  - A = zero_src ? 0 : src_val.
  - B = use_imm ? imm : dst_val.
- Single-cycle ops have one cycle of latency. On accept, the output registers load at the next edge and out_valid=1.
  - Ops: NOP(result=B), ADD, SUB(A-B), AND, OR, NOT(~B), INC(B+1), DEC(B-1), SHL/SHR(B shifted by A[3:0], zero fill).
- Flags:
  - ADD/SUB/INC/DEC/SHL/SHR update all of N, C, Z.
  - C for ADD/INC is the carry out at bit DATA_W. C for SUB/DEC is the borrow.
  - C for SHL/SHR is the last bit shifted out; C is unchanged when the shift amount is 0.
  - AND/OR/NOT update N and Z only. NOP leaves flags unchanged.
  - Flags commit in the same edge as the output register load.
- MUL:
  - On accept, the FSM goes IDLE->BUSY and the counter loads MUL_CYCLES-1. Operands and ctrl are latched.
  - In BUSY, in_ready=0. The counter decrements each cycle.
  - When the counter reaches 0 and the output is free (!out_valid || out_ready), the output loads the low DATA_W bits of the product. FSM returns to IDLE.
  - Flags on MUL: C = OR of the upper DATA_W product bits; N and Z are taken from the result.
  - Total latency is MUL_CYCLES cycles from the accept edge to out_valid.
  - If the output is blocked at count 0, the FSM stays in BUSY and holds.
- Stack pointer (updates on accept only, not on stall):
  - push: sp_out=SP, then SP<=SP-1.
  - pop: SP<=SP+1, sp_out=SP+1.
  - Wrap-around is modulo 2^SP_W.
  - sp_op is ignored (treated as 00) when alu_op==MUL.
- Backpressure: while out_valid && !out_ready, all output registers hold their values.
- Output handoff:
  - out_valid clears after handshake if no new instruction loads in the same edge.
  - A simultaneous handshake and new accept loads the new instruction with no bubble.
- Flush:
  - Next edge: out_valid=0, FSM=IDLE, counter=0.
  - A flushed MUL commits no flags.
  - Flags and SP updates already committed by accepted instructions are not rolled back.
  - Flush has priority over accept and over MUL completion.

Decomposition:
- Package exec_pkg holds:
  - the alu_op enum (NOP, ADD, SUB, AND, OR, NOT, INC, DEC, SHL, SHR, MUL);
  - SP_OP codes;
  - the flag bit indices;
  - the FSM state typedef {IDLE, BUSY}.
- One sub-module, alu_core: a purely combinational, DATA_W-parametrised ALU. It returns the result and next flags for single-cycle ops.
- Multiply sequencing, SP, flags and the handshake stay in the top level.

Test Plan:
- Reset mid-MUL: assert Reset=0 during BUSY -> out_valid=0, SP=SP_INIT, flags=0. The next ADD accepted normally.
- ADD 16'hFFFF+16'h0001 with out_ready=1 -> one cycle later result=0, Z=1, C=1, N=0, out_valid=1. SUB 5-7 -> result=16'hFFFE, N=1, C=1.
- MUL 16'h0100*16'h0100, MUL_CYCLES=4 -> in_ready=0 for 4 cycles; result=0, C=1, Z=1 on cycle 4.
- Backpressure: out_ready=0 for 3 cycles after an AND -> result, flags and ctrl_out stable; in_ready=0. Release -> next instruction loads with no bubble.
- Stack: push, push, pop from SP_INIT=32'h7FE -> sp_out 7FE, 7FD, 7FD; final SP=7FD. Push at SP=0 wraps to 32'hFFFF_FFFF.
- Flush during MUL BUSY (cycle 2) -> out_valid stays 0, flags unchanged, in_ready=1 the cycle after flush deasserts.

Source files
------------

// File: rtl/exec_pkg.sv
// Shared types for the execute stage: ALU opcodes, stack-op codes, flag bit
// positions and the multiply sequencer state.
package exec_pkg;

  typedef enum logic [3:0] {
    OP_NOP = 4'd0,
    OP_ADD = 4'd1,
    OP_SUB = 4'd2,
    OP_AND = 4'd3,
    OP_OR  = 4'd4,
    OP_NOT = 4'd5,
    OP_INC = 4'd6,
    OP_DEC = 4'd7,
    OP_SHL = 4'd8,
    OP_SHR = 4'd9,
    OP_MUL = 4'd10
  } alu_op_e;

  typedef enum logic [1:0] {
    SP_NONE = 2'b00,
    SP_PUSH = 2'b01,
    SP_POP  = 2'b10,
    SP_RSVD = 2'b11
  } sp_op_e;

  // Bit positions inside the {N,C,Z} flags vector.
  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_N = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

endpackage

// File: rtl/execute_stage_pipe_alu_core.sv
// Combinational ALU for the single-cycle operations. Returns the result and
// the flags as they should look after the operation; MUL/NOP pass flags through.
module alu_core
  import exec_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  alu_op_e           op,
  input  logic [2:0]        flags_in,
  output logic [DATA_W-1:0] result,
  output logic [2:0]        flags_out
);

  logic [DATA_W:0] ext;
  logic [DATA_W:0] shl_w;
  logic [DATA_W:0] shr_w;
  logic [3:0]      sh;
  logic            set_nz;

  assign sh = a[3:0];

  // NOTE: every variable gets a default at the top of the block so that no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    result    = b;
    flags_out = flags_in;
    ext       = '0;
    set_nz    = 1'b1;
    // One guard bit above (left shift) or below (right shift) catches the
    // last bit shifted out.
    shl_w     = {1'b0, b} << sh;
    shr_w     = {b, 1'b0} >> sh;

    case (op)
      OP_ADD: begin
        ext               = {1'b0, a} + {1'b0, b};
        result            = ext[DATA_W-1:0];
        flags_out[FLAG_C] = ext[DATA_W];
      end
      OP_SUB: begin
        ext               = {1'b0, a} - {1'b0, b};
        result            = ext[DATA_W-1:0];
        flags_out[FLAG_C] = ext[DATA_W];
      end
      OP_INC: begin
        ext               = {1'b0, b} + (DATA_W+1)'(1);
        result            = ext[DATA_W-1:0];
        flags_out[FLAG_C] = ext[DATA_W];
      end
      OP_DEC: begin
        ext               = {1'b0, b} - (DATA_W+1)'(1);
        result            = ext[DATA_W-1:0];
        flags_out[FLAG_C] = ext[DATA_W];
      end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_NOT: result = ~b;
      OP_SHL: begin
        result = shl_w[DATA_W-1:0];
        if (sh != 4'd0) flags_out[FLAG_C] = shl_w[DATA_W];
      end
      OP_SHR: begin
        result = shr_w[DATA_W:1];
        if (sh != 4'd0) flags_out[FLAG_C] = shr_w[0];
      end
      default: set_nz = 1'b0;
    endcase

    if (set_nz) begin
      flags_out[FLAG_N] = result[DATA_W-1];
      flags_out[FLAG_Z] = (result == '0);
    end
  end

endmodule

// File: rtl/execute_stage_pipe.sv
// Registered execute stage: valid/ready handshake, flags and stack pointer
// registers, a multi-cycle multiply that stalls upstream, and a flush.
module execute_stage_pipe
  import exec_pkg::*;
#(
  parameter int              DATA_W     = 16,
  parameter int              SP_W       = 32,
  parameter logic [SP_W-1:0] SP_INIT    = 32'h0000_07FE,
  parameter int              CTRL_W     = 12,
  parameter int              MUL_CYCLES = 4
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] src_val,
  input  logic [DATA_W-1:0] dst_val,
  input  logic [DATA_W-1:0] imm,
  input  logic [3:0]        alu_op,
  input  logic              zero_src,
  input  logic              use_imm,
  input  logic [1:0]        sp_op,
  input  logic [CTRL_W-1:0] ctrl_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] result,
  output logic [DATA_W-1:0] src_out,
  output logic [SP_W-1:0]   sp_out,
  output logic [2:0]        flags,
  output logic [CTRL_W-1:0] ctrl_out
);

  localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   mul_a_q, mul_a_d;
  logic [DATA_W-1:0]   mul_b_q, mul_b_d;
  logic [DATA_W-1:0]   mul_src_q, mul_src_d;
  logic [CTRL_W-1:0]   mul_ctrl_q, mul_ctrl_d;
  logic                out_valid_q, out_valid_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic [DATA_W-1:0]   src_out_q, src_out_d;
  logic [SP_W-1:0]     sp_out_q, sp_out_d;
  logic [2:0]          flags_q, flags_d;
  logic [CTRL_W-1:0]   ctrl_out_q, ctrl_out_d;
  logic [SP_W-1:0]     sp_q, sp_d;

  alu_op_e             op;
  logic [DATA_W-1:0]   operand_a, operand_b;
  logic [DATA_W-1:0]   alu_result;
  logic [2:0]          alu_flags;
  logic [2*DATA_W-1:0] product;
  logic [2:0]          mul_flags;
  logic                out_free, accept;

  assign op        = alu_op_e'(alu_op);
  assign operand_a = zero_src ? '0 : src_val;
  assign operand_b = use_imm ? imm : dst_val;

  alu_core #(.DATA_W(DATA_W)) u_alu (
    .a         (operand_a),
    .b         (operand_b),
    .op        (op),
    .flags_in  (flags_q),
    .result    (alu_result),
    .flags_out (alu_flags)
  );

  // The product settles over the BUSY window; only the latched operands feed it.
  assign product = {{DATA_W{1'b0}}, mul_a_q} * {{DATA_W{1'b0}}, mul_b_q};

  always_comb begin
    mul_flags         = '0;
    mul_flags[FLAG_N] = product[DATA_W-1];
    mul_flags[FLAG_C] = |product[2*DATA_W-1:DATA_W];
    mul_flags[FLAG_Z] = (product[DATA_W-1:0] == '0);
  end

  assign out_free = !out_valid_q || out_ready;
  assign in_ready = (state_q == ST_IDLE) && out_free && !flush;
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    mul_src_d   = mul_src_q;
    mul_ctrl_d  = mul_ctrl_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    src_out_d   = src_out_q;
    sp_out_d    = sp_out_q;
    flags_d     = flags_q;
    ctrl_out_d  = ctrl_out_q;
    sp_d        = sp_q;

    if (flush) begin
      out_valid_d = 1'b0;
      state_d     = ST_IDLE;
      cnt_d       = '0;
    end else begin
      if (out_valid_q && out_ready) out_valid_d = 1'b0;

      if (state_q == ST_BUSY) begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (out_free) begin
          out_valid_d = 1'b1;
          result_d    = product[DATA_W-1:0];
          src_out_d   = mul_src_q;
          ctrl_out_d  = mul_ctrl_q;
          flags_d     = mul_flags;
          sp_out_d    = sp_q;
          state_d     = ST_IDLE;
        end
      end else if (accept) begin
        if (op == OP_MUL) begin
          state_d    = ST_BUSY;
          cnt_d      = CNT_W'(MUL_CYCLES - 1);
          mul_a_d    = operand_a;
          mul_b_d    = operand_b;
          mul_src_d  = src_val;
          mul_ctrl_d = ctrl_in;
        end else begin
          out_valid_d = 1'b1;
          result_d    = alu_result;
          src_out_d   = src_val;
          ctrl_out_d  = ctrl_in;
          flags_d     = alu_flags;
          case (sp_op_e'(sp_op))
            SP_PUSH: begin
              sp_out_d = sp_q;
              sp_d     = sp_q - SP_W'(1);
            end
            SP_POP: begin
              sp_out_d = sp_q + SP_W'(1);
              sp_d     = sp_q + SP_W'(1);
            end
            default: sp_out_d = sp_q;
          endcase
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      mul_src_q   <= '0;
      mul_ctrl_q  <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      src_out_q   <= '0;
      sp_out_q    <= SP_INIT;
      flags_q     <= '0;
      ctrl_out_q  <= '0;
      sp_q        <= SP_INIT;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      mul_src_q   <= mul_src_d;
      mul_ctrl_q  <= mul_ctrl_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      src_out_q   <= src_out_d;
      sp_out_q    <= sp_out_d;
      flags_q     <= flags_d;
      ctrl_out_q  <= ctrl_out_d;
      sp_q        <= sp_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign src_out   = src_out_q;
  assign sp_out    = sp_out_q;
  assign flags     = flags_q;
  assign ctrl_out  = ctrl_out_q;

endmodule

// File: tb/tb_execute_stage_pipe.sv
// Bench for execute_stage_pipe: directed scenarios followed by random traffic,
// all checked against a transaction-level reference model.
module tb_execute_stage_pipe;
  import exec_pkg::*;

  localparam int          MUL_CYCLES = 4;
  localparam logic [31:0] SP_RESET   = 32'h0000_07FE;

  logic        CLK, Reset, flush, in_valid, in_ready, zero_src, use_imm;
  logic        out_valid, out_ready;
  logic [15:0] src_val, dst_val, imm, result, src_out;
  logic [3:0]  alu_op;
  logic [1:0]  sp_op;
  logic [11:0] ctrl_in, ctrl_out;
  logic [31:0] sp_out;
  logic [2:0]  flags;

  int n_checks = 0;
  int n_fail   = 0;

  execute_stage_pipe #(
    .DATA_W(16), .SP_W(32), .SP_INIT(SP_RESET), .CTRL_W(12), .MUL_CYCLES(MUL_CYCLES)
  ) dut (
    .CLK(CLK), .Reset(Reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .src_val(src_val), .dst_val(dst_val), .imm(imm), .alu_op(alu_op),
    .zero_src(zero_src), .use_imm(use_imm), .sp_op(sp_op), .ctrl_in(ctrl_in),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .src_out(src_out),
    .sp_out(sp_out), .flags(flags), .ctrl_out(ctrl_out)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        v;
    alu_op_e     op;
    logic [15:0] src, dst, imm;
    logic        zs, ui;
    logic [1:0]  spo;
    logic [11:0] ctrl;
    logic        ordy;
    logic        fl;
  } stim_t;

  // Reference model state: what the stage should present, plus a pending multiply.
  logic        m_ov, m_busy;
  int          m_left;
  logic [2:0]  m_flags;
  logic [31:0] m_sp, m_spo;
  logic [15:0] m_res, m_src;
  logic [11:0] m_ctrl;
  logic [15:0] p_res, p_src;
  logic [2:0]  p_flags;
  logic [11:0] p_ctrl;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Behavioural ALU from the arithmetic definitions; returns result and new {N,C,Z}.
  function automatic void ref_exec(input alu_op_e op, input logic [15:0] a, input logic [15:0] b,
                                   input logic [2:0] fin, output logic [15:0] r,
                                   output logic [2:0] fo);
    int unsigned ua = a;
    int unsigned ub = b;
    int unsigned sh = a[3:0];
    int unsigned p;
    logic c = fin[1];
    bit upd = 1'b1;
    r = b;
    case (op)
      OP_ADD: begin r = 16'(ua + ub); c = (ua + ub) > 32'd65535; end
      OP_SUB: begin r = 16'(ua - ub); c = ua < ub; end
      OP_AND: r = a & b;
      OP_OR:  r = a | b;
      OP_NOT: r = ~b;
      OP_INC: begin r = 16'(ub + 1); c = (ub == 32'd65535); end
      OP_DEC: begin r = 16'(ub - 1); c = (ub == 32'd0); end
      OP_SHL: begin
        r = 16'(ub << sh);
        if (sh != 0) c = ((ub << sh) & 32'h0001_0000) != 0;
      end
      OP_SHR: begin
        r = 16'(ub >> sh);
        if (sh != 0) c = ((ub >> (sh - 1)) & 32'd1) != 0;
      end
      OP_MUL: begin
        p = ua * ub;
        r = 16'(p);
        c = (p >> 16) != 0;
      end
      default: upd = 1'b0;
    endcase
    fo = upd ? {r[15], c, (r == 16'h0000)} : fin;
  endfunction

  function automatic stim_t instr(input alu_op_e op, input logic [15:0] src, input logic [15:0] dst,
                                  input logic [1:0] spo, input logic ordy, input logic [11:0] ctrl);
    stim_t s;
    s.v = 1'b1; s.op = op; s.src = src; s.dst = dst; s.imm = 16'h0;
    s.zs = 1'b0; s.ui = 1'b0; s.spo = spo; s.ctrl = ctrl; s.ordy = ordy; s.fl = 1'b0;
    return s;
  endfunction

  function automatic stim_t idle(input logic ordy);
    stim_t s;
    s = instr(OP_NOP, 16'h0, 16'h0, 2'b00, ordy, 12'h0);
    s.v = 1'b0;
    return s;
  endfunction

  task automatic model_reset();
    m_ov = 1'b0; m_busy = 1'b0; m_left = 0; m_flags = 3'b000; m_sp = SP_RESET;
    m_spo = SP_RESET; m_res = 16'h0; m_src = 16'h0; m_ctrl = 12'h0;
  endtask

  // One clock cycle: drive at the falling edge, compare, advance the model.
  task automatic step(input stim_t s);
    logic        exp_rdy, acc, free;
    logic [15:0] a, b, r;
    logic [2:0]  f;
    in_valid = s.v; alu_op = s.op; src_val = s.src; dst_val = s.dst; imm = s.imm;
    zero_src = s.zs; use_imm = s.ui; sp_op = s.spo; ctrl_in = s.ctrl;
    out_ready = s.ordy; flush = s.fl;
    #1;
    exp_rdy = !m_busy && (!m_ov || s.ordy) && !s.fl;
    check("in_ready", in_ready, exp_rdy);
    check("out_valid", out_valid, m_ov);
    check("flags", flags, m_flags);
    if (m_ov) begin
      check("result", result, m_res);
      check("src_out", src_out, m_src);
      check("sp_out", sp_out, m_spo);
      check("ctrl_out", ctrl_out, m_ctrl);
    end

    acc = s.v && exp_rdy;
    a = s.zs ? 16'h0 : s.src;
    b = s.ui ? s.imm : s.dst;
    if (s.fl) begin
      m_ov = 1'b0;
      m_busy = 1'b0;
    end else begin
      free = !m_ov || s.ordy;
      if (m_ov && s.ordy) m_ov = 1'b0;
      if (m_busy) begin
        if (m_left > 0) m_left--;
        else if (free) begin
          m_ov = 1'b1; m_busy = 1'b0;
          m_res = p_res; m_src = p_src; m_ctrl = p_ctrl; m_flags = p_flags; m_spo = m_sp;
        end
      end else if (acc) begin
        ref_exec(s.op, a, b, m_flags, r, f);
        if (s.op == OP_MUL) begin
          m_busy = 1'b1; m_left = MUL_CYCLES - 1;
          p_res = r; p_flags = f; p_src = s.src; p_ctrl = s.ctrl;
        end else begin
          m_ov = 1'b1; m_res = r; m_flags = f; m_src = s.src; m_ctrl = s.ctrl;
          if (s.spo == 2'b01) begin m_spo = m_sp; m_sp = m_sp - 32'd1; end
          else if (s.spo == 2'b10) begin m_sp = m_sp + 32'd1; m_spo = m_sp; end
          else m_spo = m_sp;
        end
      end
    end
    @(posedge CLK);
    @(negedge CLK);
  endtask

  initial begin
    stim_t s;
    Reset = 1'b0;
    in_valid = 1'b0; alu_op = 4'd0; src_val = '0; dst_val = '0; imm = '0;
    zero_src = 1'b0; use_imm = 1'b0; sp_op = 2'b00; ctrl_in = '0; out_ready = 1'b0; flush = 1'b0;
    model_reset();
    repeat (2) @(negedge CLK);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_src_out", src_out, 0);
    check("rst_ctrl_out", ctrl_out, 0);
    check("rst_flags", flags, 0);
    check("rst_sp_out", sp_out, SP_RESET);
    @(negedge CLK);
    Reset = 1'b1;

    // Reset in the middle of a multiply leaves no residue.
    step(instr(OP_MUL, 16'd3, 16'd5, 2'b00, 1'b1, 12'h111));
    step(idle(1'b1));
    Reset = 1'b0;
    #1;
    check("midmul_rst_valid", out_valid, 0);
    check("midmul_rst_flags", flags, 0);
    check("midmul_rst_sp", sp_out, SP_RESET);
    model_reset();
    @(posedge CLK);
    @(negedge CLK);
    Reset = 1'b1;
    step(instr(OP_ADD, 16'd2, 16'd3, 2'b00, 1'b1, 12'h222));
    check("post_rst_add_valid", out_valid, 1);
    check("post_rst_add_res", result, 16'd5);

    // Carry and borrow.
    step(instr(OP_ADD, 16'hFFFF, 16'h0001, 2'b00, 1'b1, 12'h001));
    check("add_carry_res", result, 16'h0000);
    check("add_carry_flags", flags, 3'b011);
    step(instr(OP_SUB, 16'd5, 16'd7, 2'b00, 1'b1, 12'h002));
    check("sub_borrow_res", result, 16'hFFFE);
    check("sub_borrow_flags", flags, 3'b110);

    // Multiply latency and overflow into C.
    step(instr(OP_MUL, 16'h0100, 16'h0100, 2'b00, 1'b1, 12'h003));
    check("mul_busy_rdy", in_ready, 0);
    for (int i = 0; i < MUL_CYCLES - 1; i++) begin
      step(idle(1'b1));
      check("mul_busy_rdy", in_ready, 0);
      check("mul_busy_valid", out_valid, 0);
    end
    step(idle(1'b1));
    check("mul_done_valid", out_valid, 1);
    check("mul_done_res", result, 16'h0000);
    check("mul_done_flags", flags, 3'b011);
    check("mul_done_ctrl", ctrl_out, 12'h003);

    // Backpressure holds the AND result; the waiting OR loads without a bubble.
    step(instr(OP_AND, 16'hF0F0, 16'h0FF0, 2'b00, 1'b1, 12'hA5C));
    for (int i = 0; i < 3; i++) begin
      step(instr(OP_OR, 16'h1234, 16'h4321, 2'b00, 1'b0, 12'h3C3));
      check("bp_result", result, 16'h00F0);
      check("bp_flags", flags, 3'b010);
      check("bp_ctrl", ctrl_out, 12'hA5C);
      check("bp_in_ready", in_ready, 0);
    end
    step(instr(OP_OR, 16'h1234, 16'h4321, 2'b00, 1'b1, 12'h3C3));
    check("bp_release_valid", out_valid, 1);
    check("bp_release_res", result, 16'h5335);
    check("bp_release_ctrl", ctrl_out, 12'h3C3);
    step(idle(1'b1));
    check("drain_valid", out_valid, 0);

    // Stack: push, push, pop, then walk down to zero and wrap.
    step(instr(OP_NOP, 16'h0, 16'h0, 2'b01, 1'b1, 12'h0));
    check("push1_sp", sp_out, 32'h7FE);
    step(instr(OP_NOP, 16'h0, 16'h0, 2'b01, 1'b1, 12'h0));
    check("push2_sp", sp_out, 32'h7FD);
    step(instr(OP_NOP, 16'h0, 16'h0, 2'b10, 1'b1, 12'h0));
    check("pop_sp", sp_out, 32'h7FD);
    step(instr(OP_NOP, 16'h0, 16'h0, 2'b00, 1'b1, 12'h0));
    check("final_sp", sp_out, 32'h7FD);
    for (int i = 0; i < 32'h7FD; i++) step(instr(OP_NOP, 16'h0, 16'h0, 2'b01, 1'b1, 12'h0));
    step(instr(OP_NOP, 16'h0, 16'h0, 2'b01, 1'b1, 12'h0));
    check("push_at_zero_sp", sp_out, 32'h0);
    step(instr(OP_NOP, 16'h0, 16'h0, 2'b00, 1'b1, 12'h0));
    check("wrap_sp", sp_out, 32'hFFFF_FFFF);

    // Flush during BUSY drops the multiply and its flags.
    step(instr(OP_MUL, 16'h0, 16'd5, 2'b00, 1'b1, 12'h0F0));
    step(idle(1'b1));
    s = idle(1'b1);
    s.fl = 1'b1;
    step(s);
    flush = 1'b0;
    #1;
    check("flush_in_ready", in_ready, 1);
    check("flush_valid", out_valid, 0);
    check("flush_flags", flags, 3'b010);
    repeat (MUL_CYCLES + 2) step(idle(1'b1));

    // Random traffic with backpressure, immediates, zero_src and occasional flush.
    for (int i = 0; i < 1500; i++) begin
      s.v    = $urandom_range(0, 9) < 7;
      s.op   = alu_op_e'($urandom_range(0, 10));
      s.src  = 16'($urandom);
      s.dst  = 16'($urandom);
      s.imm  = 16'($urandom);
      s.zs   = $urandom_range(0, 7) == 0;
      s.ui   = 1'($urandom_range(0, 1));
      s.spo  = 2'($urandom);
      s.ctrl = 12'($urandom);
      s.ordy = $urandom_range(0, 9) < 7;
      s.fl   = $urandom_range(0, 49) == 0;
      step(s);
    end
    repeat (MUL_CYCLES + 2) step(idle(1'b1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
